// File: rtl/esp_uart_rx.sv
// esp_uart_rx: receiving end of the ESP serial link (SoC esp_uart_txd -> FPGA).
// Samples the asynchronous rxd line at 16x the bit rate, deframes 8N1 bytes,
// buffers them in a show-ahead FIFO and presents them on a valid/ready byte
// stream. Framing errors and FIFO overruns are reported as sticky flags.
//
// Ports:
//   clk_clk        fabric clock
//   reset_reset_n  asynchronous active-low reset
//   rxd            serial input, idle high, asynchronous to clk_clk
//   rx_data        byte at FIFO head, meaningful while rx_valid=1
//   rx_valid       FIFO not empty
//   rx_ready       consumer accept; pop when rx_valid & rx_ready at a rising edge
//   fifo_count     FIFO occupancy, 0..FIFO_DEPTH
//   frame_err      sticky: a stop bit was sampled low
//   overrun        sticky: a byte was dropped because the FIFO was full
//   err_clear      synchronous clear of frame_err and overrun (wins over a set)

module esp_uart_rx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    // Reject FIFO depths the natural pointer wrap cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("esp_uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; idle-high reset so reset never fakes a start.
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_s_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // 16x tick generator, re-phased on start detection.
    // ------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              tick_c;
    logic              start_det_c;

    assign tick_c      = (div_q == DIV_W'(DIV - 1));
    assign start_det_c = (state_q == IDLE) && !rxd_s_q;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (start_det_c || tick_c) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Deframing FSM: state register.
    // ------------------------------------------------------------------
    logic [3:0] tc_q;
    logic [3:0] tc_d;
    logic [2:0] bit_idx_q;
    logic [2:0] bit_idx_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       push_c;
    logic       ferr_set_c;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            tc_q      <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Deframing FSM: next state and push / frame-error strobes.
    // tc is 4 bits, so the 16th tick naturally wraps it back to 0.
    always_comb begin
        state_d    = state_q;
        tc_d       = tc_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxd_s_q) begin
                    state_d = START;
                    tc_d    = '0;
                end
            end

            START: begin
                if (tick_c) begin
                    if (tc_q == 4'd7) begin
                        // Mid start bit: still low means a real frame.
                        if (!rxd_s_q) begin
                            state_d   = DATA;
                            tc_d      = '0;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick_c) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        // LSB first: shift in at the top, byte lands aligned after 8.
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
            end

            STOP: begin
                if (tick_c) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        if (rxd_s_q) begin
                            push_c  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_set_c = 1'b1;
                            state_d    = WAIT_HIGH;
                        end
                    end
                end
            end

            WAIT_HIGH: begin
                // Hold off through a break so it flags only once.
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead byte FIFO.
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_c;
    logic             pop_c;
    logic             wr_en_c;
    logic             ovr_set_c;

    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c     = rx_valid && rx_ready;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en_c   = push_c && (!full_c || pop_c);
    assign ovr_set_c = push_c && full_c && !pop_c;

    always_comb begin
        count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is cleared on reset so rx_data reads 0 out of reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; clear wins over a same-cycle set.
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (err_clear) begin
                frame_err_q <= 1'b0;
            end else if (ferr_set_c) begin
                frame_err_q <= 1'b1;
            end
            if (err_clear) begin
                overrun_q <= 1'b0;
            end else if (ovr_set_c) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_esp_uart_rx.sv
// tb_esp_uart_rx: directed bench for esp_uart_rx at DIV=1 (one bit = 16 clocks).
`timescale 1ns/1ps

module tb_esp_uart_rx;

    localparam int unsigned CLK_HZ     = 1843200;
    localparam int unsigned BAUD       = 115200;
    localparam int unsigned FIFO_DEPTH = 16;

    logic       clk_clk;
    logic       reset_reset_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q [$];

    esp_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .fifo_count    (fifo_count),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .err_clear     (err_clear)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake monitor: every pop must match the next expected byte.
    always @(negedge clk_clk) begin
        if (reset_reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no byte at %0t", rx_data, $time);
            end else begin
                check("pop_data", int'(rx_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    // Start bit plus 8 data bits, LSB first; entered just after a rising edge.
    task automatic send_bits(input logic [7:0] b);
        rxd = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(16);
        end
    endtask

    // Full frame. pulse=1 pops, pulse=2 clears errors, exactly on the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pulse);
        send_bits(b);
        rxd = stop;
        for (int i = 0; i < 16; i++) begin
            if (i == 10 && pulse == 1) rx_ready = 1'b1;
            if (i == 10 && pulse == 2) err_clear = 1'b1;
            if (i == 11 && pulse == 1) rx_ready = 1'b0;
            if (i == 11 && pulse == 2) err_clear = 1'b0;
            @(posedge clk_clk);
            #1;
        end
        rxd = 1'b1;
        if (!stop) cyc(16);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_count;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 2, 1'b0};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hA5, 2, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1, 1'b1};
        vecs[5] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b1};

        rxd           = 1'b1;
        rx_ready      = 1'b0;
        err_clear     = 1'b0;
        reset_reset_n = 1'b0;
        cyc(3);
        check("rst_rx_data",    int'(rx_data),    0);
        check("rst_rx_valid",   int'(rx_valid),   0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_frame_err",  int'(frame_err),  0);
        check("rst_overrun",    int'(overrun),    0);
        reset_reset_n = 1'b1;
        cyc(4);

        // Table: single frames with cumulative FIFO / flag expectations.
        for (int v = 0; v < 6; v++) begin
            rx_ready = vecs[v].rdy;
            if (vecs[v].stop) exp_q.push_back(vecs[v].b);
            send_frame(vecs[v].b, vecs[v].stop, 0);
            check($sformatf("vec%0d_valid", v), int'(rx_valid), int'(vecs[v].exp_valid));
            check($sformatf("vec%0d_count", v), int'(fifo_count), vecs[v].exp_count);
            check($sformatf("vec%0d_ferr", v),  int'(frame_err), int'(vecs[v].exp_ferr));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_data", v), int'(rx_data), int'(vecs[v].exp_data));
        end
        rx_ready = 1'b0;

        // Clear, clear-beats-set, and re-set of frame_err.
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        check("ferr_cleared", int'(frame_err), 0);
        send_frame(8'h66, 1'b0, 2);
        check("ferr_clear_priority", int'(frame_err), 0);
        send_frame(8'h66, 1'b0, 0);
        check("ferr_reset_later", int'(frame_err), 1);
        check("ferr_no_push", int'(fifo_count), 1);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        rx_ready = 1'b1;
        cyc(4);
        check("drain1_count", int'(fifo_count), 0);

        // Back-to-back frames streamed straight through.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        cyc(2);
        check("b2b_count", int'(fifo_count), 0);
        check("b2b_all_popped", exp_q.size(), 0);

        // Break: low stop then 40 bit times low; only one frame error.
        send_bits(8'h55);
        rxd = 1'b0;
        cyc(16);
        check("break_ferr", int'(frame_err), 1);
        cyc(320);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        check("break_clear", int'(frame_err), 0);
        cyc(320);
        check("break_single_ferr", int'(frame_err), 0);
        check("break_no_byte", int'(fifo_count), 0);
        rxd = 1'b1;
        cyc(32);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0);
        cyc(2);
        check("after_break_rx", exp_q.size(), 0);

        // Four-clock glitch, then a frame right behind it.
        rxd = 1'b0;
        cyc(4);
        rxd = 1'b1;
        cyc(8);
        check("glitch_ferr", int'(frame_err), 0);
        check("glitch_count", int'(fifo_count), 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 0);
        cyc(2);
        check("after_glitch_rx", exp_q.size(), 0);
        check("after_glitch_ferr", int'(frame_err), 0);

        // Overrun: 17 bytes into a 16-entry FIFO.
        rx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 0);
        end
        check("ovr_count", int'(fifo_count), 16);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_head", int'(rx_data), 0);
        rx_ready = 1'b1;
        cyc(20);
        rx_ready = 1'b0;
        check("ovr_drained", int'(fifo_count), 0);
        check("ovr_no_extra", exp_q.size(), 0);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        check("ovr_cleared", int'(overrun), 0);

        // Rerun: pop on the 17th stop-sample edge, so 0x10 is accepted.
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, (i == 16) ? 1 : 0);
        end
        check("full_pp_count", int'(fifo_count), 16);
        check("full_pp_ovr", int'(overrun), 0);
        check("full_pp_head", int'(rx_data), 1);
        rx_ready = 1'b1;
        cyc(20);
        rx_ready = 1'b0;
        check("full_pp_drained", exp_q.size(), 0);

        // Reset mid-frame with a byte buffered and frame_err set.
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 0);
        send_frame(8'h11, 1'b0, 0);
        check("pre_rst_valid", int'(rx_valid), 1);
        check("pre_rst_ferr", int'(frame_err), 1);
        rxd = 1'b0;
        cyc(16);
        for (int i = 0; i < 4; i++) begin
            rxd = (i == 0) ? 1'b1 : 1'b0;
            cyc(16);
        end
        rxd = 1'b0;
        cyc(8);
        reset_reset_n = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_rx_data",    int'(rx_data),    0);
        check("midrst_rx_valid",   int'(rx_valid),   0);
        check("midrst_fifo_count", int'(fifo_count), 0);
        check("midrst_frame_err",  int'(frame_err),  0);
        check("midrst_overrun",    int'(overrun),    0);
        cyc(3);
        reset_reset_n = 1'b1;
        cyc(20);
        check("post_rst_count", int'(fifo_count), 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 0);
        cyc(4);
        check("post_rst_rx", exp_q.size(), 0);
        check("post_rst_ferr", int'(frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
